register_tree_cycled: RTL and testbench
=======================================

Name: register_tree_cycled

Overview:
- Register-based max-priority queue; QUEUE_SIZE slots form an implicit binary heap (node i has children 2i+1 and 2i+2).
- Ordering is maintained by a "cycled" compare-swap network: even-level parent nodes and odd-level parent nodes are processed on alternating clock cycles.
- The root (maximum) is always presented on o_data.
- Used as a scheduler/sorter queue. Enqueue can be compiled out via ENQ_ENA, giving a dequeue/replace-only queue for preloaded contents.

Parameters:
- ENQ_ENA, 1'b1, 1 = standalone enqueue accepted; 0 = i_wrt without i_read is ignored.
- QUEUE_SIZE, 15, number of slots (any value ≥ 2; full trees 2^k-1 are the primary target).
- DATA_WIDTH, 16, element width, unsigned.

Ports:
- i_CLK  in  1  clock, rising edge.
- i_RSTn  in  1  asynchronous active-low reset.
- i_wrt  in  1  write request (enqueue; with i_read = replace).
- i_read  in  1  read request (dequeue; with i_wrt = replace).
- i_data  in  DATA_WIDTH  value to enqueue/replace.
- o_full  out  1  size == QUEUE_SIZE.
- o_empty  out  1  size == 0.
- o_data  out  DATA_WIDTH  queue[0] (current maximum); 0 when empty.

Behaviour:
- State:
  - queue[0..QUEUE_SIZE-1] registers with combinational next_queue[].
  - size register, width $clog2(QUEUE_SIZE+1), with next_size.
  - phase bit.
  - queue/next_queue/size/next_size are named exactly so: verification preloads them hierarchically.
- Reset (async, i_RSTn=0): all queue slots 0, size 0, phase 0 (even). Outputs: o_empty=1, o_full=0, o_data=0.
- Unoccupied slots (index ≥ size) always hold 0.
- Phase toggles every cycle.
  - phase=0: every parent node at an even level compares with its children.
  - phase=1: every parent node at an odd level compares with its children.
  - Compare rule: if max(child) > parent, swap parent with the larger child (left child wins ties). Children beyond QUEUE_SIZE are ignored.
- Operation decode, sampled at the rising edge. The operation is applied to the queue state first; the compare-swap of that cycle's phase is applied to the result in the same edge.
  - Enqueue (i_wrt=1, i_read=0): ENQ_ENA=1 and !full → queue[size]=i_data, size+1. Full or ENQ_ENA=0 → no change.
  - Dequeue (i_wrt=0, i_read=1): !empty → queue[0]=queue[size-1], queue[size-1]=0, size-1. Empty → no change.
  - Replace (i_wrt=1, i_read=1):
    - !empty → queue[0]=i_data, size unchanged.
    - empty → behaves as insert at slot 0, size becomes 1.
    - Replace is accepted regardless of ENQ_ENA.
  - Idle: only compare-swap.
- Latency, with idle cycles after the operation:
  - o_data is the correct maximum within 2 cycles after a dequeue/replace edge.
  - o_data is the correct maximum within 1+$clog2(QUEUE_SIZE) cycles after an enqueue edge.
  - o_full/o_empty update on the operation edge.
- Back-to-back operations are legal. The heap converges once inputs idle for the latencies above.
- Values are unsigned. Duplicates are allowed. Value 0 is legal but indistinguishable from padding.

Optional Feature:
- Macro REGISTER_TREE_CYCLED_ASSERT_EN.
- Defined: include simulation-only assertions:
  - $error on enqueue while full.
  - $error on dequeue while empty.
  - $warning on standalone enqueue when ENQ_ENA=0.
  - $error if any slot ≥ size is nonzero.
- Undefined: no checking logic. RTL behaviour is identical either way.

Test Plan:
- Reset → o_empty=1, o_full=0, o_data=0. Enqueue 15 values (ENQ_ENA=1), waiting 5 cycles each → o_full=1, o_data = max of values.
- ENQ_ENA=1 full queue: 7 dequeues with 3-cycle spacing → o_data equals next sorted-descending value each time, size 8.
- ENQ_ENA=1: enqueue 1000 into queue holding {500,300} → o_data=1000 after 5 cycles. Replace with 10 → o_data=500 after 3 cycles, size unchanged.
- ENQ_ENA=0:
  - Preload next_queue with 15 descending values and next_size=15 → o_full=1.
  - 7 dequeues track the sorted order.
  - 7 enqueues → o_data, size and flags unchanged (o_full=0, o_empty=0).
- ENQ_ENA=0: replace stream of random values 0..1024 → o_data always equals model maximum after 3 cycles.
- Empty queue: dequeue → no change, o_data=0. Replace with 42 → o_empty=0, o_data=42.

Source files
------------

// File: rtl/register_tree_cycled.sv
// Max-priority queue held in registers as an implicit binary heap; root (maximum) always on o_data.
// Latency: flags update on the operation edge; root valid <=2 cycles after dequeue/replace, <=1+clog2(QUEUE_SIZE) after enqueue.
// Backpressure: none; enqueue while full / dequeue while empty are dropped. Optional checks: REGISTER_TREE_CYCLED_ASSERT_EN.
module register_tree_cycled #(
    parameter logic ENQ_ENA    = 1'b1,
    parameter int   QUEUE_SIZE = 15,
    parameter int   DATA_WIDTH = 16
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    input  logic                  i_wrt,
    input  logic                  i_read,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int SW = $clog2(QUEUE_SIZE + 1);
    localparam int IW = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;

    typedef logic [IW-1:0] idx_t;

    // Slot contents after the operation, before this cycle's compare-swap
    logic [QUEUE_SIZE-1:0][DATA_WIDTH-1:0] op_queue;
    logic [QUEUE_SIZE-1:0][DATA_WIDTH-1:0] next_queue;
    logic [QUEUE_SIZE-1:0][DATA_WIDTH-1:0] queue;
    logic [SW-1:0]                         size;
    logic [SW-1:0]                         next_size;
    logic                                  phase_q;
    logic                                  phase_d;
    logic                                  full;
    logic                                  empty;

    // Level parity of heap node idx: level = floor(log2(idx+1))
    function automatic logic odd_level(input int idx);
        int lvl;
        lvl = 0;
        for (int b = 1; b < 32; b++) begin
            if (((idx + 1) >> b) != 0) begin
                lvl = b;
            end
        end
        return lvl[0];
    endfunction

    assign full    = (size == SW'(QUEUE_SIZE));
    assign empty   = (size == '0);
    assign o_full  = full;
    assign o_empty = empty;
    assign o_data  = queue[0];

    // Apply the requested operation to the registered slots
    always_comb begin
        op_queue  = queue;
        next_size = size;
        if (i_wrt && i_read) begin
            // Replace overwrites the root; on an empty queue this is an insert at slot 0
            op_queue[0] = i_data;
            if (empty) begin
                next_size = SW'(1);
            end
        end else if (i_wrt) begin
            if (ENQ_ENA && !full) begin
                for (int k = 0; k < QUEUE_SIZE; k++) begin
                    if (k == int'(size)) begin
                        op_queue[idx_t'(k)] = i_data;
                    end
                end
                next_size = size + SW'(1);
            end
        end else if (i_read) begin
            if (!empty) begin
                // Last leaf moves to the root and its slot returns to padding;
                // with one element the root itself ends up cleared
                for (int k = 0; k < QUEUE_SIZE; k++) begin
                    if (k == int'(size) - 1) begin
                        op_queue[0]         = queue[idx_t'(k)];
                        op_queue[idx_t'(k)] = '0;
                    end
                end
                next_size = size - SW'(1);
            end
        end
    end

    // Compare-swap every parent on the active level parity; pairs never overlap within a phase
    always_comb begin
        idx_t pidx;
        idx_t lidx;
        idx_t ridx;
        idx_t big;
        next_queue = op_queue;
        pidx       = '0;
        lidx       = '0;
        ridx       = '0;
        big        = '0;
        for (int p = 0; p < QUEUE_SIZE / 2; p++) begin
            if (odd_level(p) == phase_q) begin
                pidx = idx_t'(p);
                lidx = idx_t'(2 * p + 1);
                ridx = (2 * p + 2 < QUEUE_SIZE) ? idx_t'(2 * p + 2) : lidx;
                big  = (op_queue[ridx] > op_queue[lidx]) ? ridx : lidx;
                if (op_queue[big] > op_queue[pidx]) begin
                    next_queue[pidx] = op_queue[big];
                    next_queue[big]  = op_queue[pidx];
                end
            end
        end
    end

    // Phase alternates every cycle between even-level and odd-level parents
    always_comb begin
        phase_d = ~phase_q;
    end

    // State registers
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            queue   <= '0;
            size    <= '0;
            phase_q <= 1'b0;
        end else begin
            queue   <= next_queue;
            size    <= next_size;
            phase_q <= phase_d;
        end
    end

`ifdef REGISTER_TREE_CYCLED_ASSERT_EN
    // Simulation-only protocol and padding-invariant checks
    always @(posedge i_CLK) begin
        if (i_RSTn) begin
            if (i_wrt && !i_read && full) begin
                $error("register_tree_cycled: enqueue while full");
            end
            if (i_read && !i_wrt && empty) begin
                $error("register_tree_cycled: dequeue while empty");
            end
            if (i_wrt && !i_read && !ENQ_ENA) begin
                $warning("register_tree_cycled: standalone enqueue ignored (enqueue disabled)");
            end
            for (int k = 0; k < QUEUE_SIZE; k++) begin
                if ((k >= int'(size)) && (queue[idx_t'(k)] != '0)) begin
                    $error("register_tree_cycled: unoccupied slot %0d is nonzero", k);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_register_tree_cycled.sv
// Directed bench for register_tree_cycled: enqueue-enabled and replace-only instances.
// Table-driven vectors on the enqueue-enabled queue, hand sequences for preload/replace stream/reset.
// Outputs are sampled on the falling edge, inputs driven on the falling edge.
module tb_register_tree_cycled;

    localparam int QS = 15;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_wrt, a_read, a_full, a_empty;
    logic [DW-1:0] a_data, a_q;
    logic          b_wrt, b_read, b_full, b_empty;
    logic [DW-1:0] b_data, b_q;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    register_tree_cycled #(.ENQ_ENA(1'b1), .QUEUE_SIZE(QS), .DATA_WIDTH(DW)) u_dut (
        .i_CLK(clk), .i_RSTn(rst_n), .i_wrt(a_wrt), .i_read(a_read), .i_data(a_data),
        .o_full(a_full), .o_empty(a_empty), .o_data(a_q)
    );

    register_tree_cycled #(.ENQ_ENA(1'b0), .QUEUE_SIZE(QS), .DATA_WIDTH(DW)) u_dut0 (
        .i_CLK(clk), .i_RSTn(rst_n), .i_wrt(b_wrt), .i_read(b_read), .i_data(b_data),
        .o_full(b_full), .o_empty(b_empty), .o_data(b_q)
    );

    typedef struct {
        logic wrt;
        logic rd;
        int   dat;
        int   idle;
        int   exp_data;
        logic exp_full;
        logic exp_empty;
        int   exp_size;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic r, input int d, input int idle,
                                input int ed, input logic ef, input logic ee, input int es);
        vec_t v;
        v.wrt = w; v.rd = r; v.dat = d; v.idle = idle;
        v.exp_data = ed; v.exp_full = ef; v.exp_empty = ee; v.exp_size = es;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One operation cycle on the selected queue, then idle cycles; returns at a falling edge
    task automatic op(input bit sel, input logic w, input logic r, input int d, input int idle);
        @(negedge clk);
        if (sel) begin
            b_wrt = w; b_read = r; b_data = DW'(d);
        end else begin
            a_wrt = w; a_read = r; a_data = DW'(d);
        end
        @(negedge clk);
        if (sel) begin
            b_wrt = 1'b0; b_read = 1'b0; b_data = '0;
        end else begin
            a_wrt = 1'b0; a_read = 1'b0; a_data = '0;
        end
        repeat (idle) @(negedge clk);
    endtask

    vec_t vt[$];
    int   enq_vals[15] = '{40, 10, 70, 25, 90, 5, 60, 15, 80, 35, 100, 50, 20, 95, 30};
    int   enq_max[15]  = '{40, 40, 70, 70, 90, 90, 90, 90, 90, 90, 100, 100, 100, 100, 100};
    int   deq_exp[15]  = '{95, 90, 80, 70, 60, 50, 40, 35, 30, 25, 20, 15, 10, 5, 0};
    logic [QS-1:0][DW-1:0] pre;
    int   model[$];

    initial begin
        a_wrt = 1'b0; a_read = 1'b0; a_data = '0;
        b_wrt = 1'b0; b_read = 1'b0; b_data = '0;
        rst_n = 1'b0;

        // Vector table for the enqueue-enabled queue
        for (int i = 0; i < 15; i++)
            vt.push_back(mk(1'b1, 1'b0, enq_vals[i], 5, enq_max[i], (i == 14), 1'b0, i + 1));
        vt.push_back(mk(1'b1, 1'b0, 200, 5, 100, 1'b1, 1'b0, 15));          // enqueue while full
        for (int i = 0; i < 15; i++)
            vt.push_back(mk(1'b0, 1'b1, 0, 3, deq_exp[i], 1'b0, (i == 14), 14 - i));
        vt.push_back(mk(1'b1, 1'b0, 500, 5, 500, 1'b0, 1'b0, 1));
        vt.push_back(mk(1'b1, 1'b0, 300, 5, 500, 1'b0, 1'b0, 2));
        vt.push_back(mk(1'b1, 1'b0, 1000, 5, 1000, 1'b0, 1'b0, 3));
        vt.push_back(mk(1'b1, 1'b1, 10, 3, 500, 1'b0, 1'b0, 3));            // replace root
        vt.push_back(mk(1'b0, 1'b1, 0, 3, 300, 1'b0, 1'b0, 2));
        vt.push_back(mk(1'b0, 1'b1, 0, 3, 10, 1'b0, 1'b0, 1));
        vt.push_back(mk(1'b0, 1'b1, 0, 3, 0, 1'b0, 1'b1, 0));
        vt.push_back(mk(1'b0, 1'b1, 0, 3, 0, 1'b0, 1'b1, 0));               // dequeue while empty
        vt.push_back(mk(1'b1, 1'b1, 42, 3, 42, 1'b0, 1'b0, 1));             // replace on empty

        repeat (2) @(negedge clk);
        check("reset a_empty", int'(a_empty), 1);
        check("reset a_full", int'(a_full), 0);
        check("reset a_data", int'(a_q), 0);
        check("reset b_empty", int'(b_empty), 1);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            op(1'b0, vt[i].wrt, vt[i].rd, vt[i].dat, vt[i].idle);
            check($sformatf("vec%0d data", i), int'(a_q), vt[i].exp_data);
            check($sformatf("vec%0d full", i), int'(a_full), int'(vt[i].exp_full));
            check($sformatf("vec%0d empty", i), int'(a_empty), int'(vt[i].exp_empty));
            check($sformatf("vec%0d size", i), int'(u_dut.size), vt[i].exp_size);
        end

        // Flags and root react on the operation edge itself
        op(1'b0, 1'b0, 1'b1, 0, 0);
        check("edge deq empty", int'(a_empty), 1);
        check("edge deq data", int'(a_q), 0);
        op(1'b0, 1'b1, 1'b0, 7, 0);
        check("edge enq empty", int'(a_empty), 0);
        check("edge enq data", int'(a_q), 7);

        // Replace-only queue: preload a full sorted heap
        for (int i = 0; i < QS; i++) pre[i] = DW'(150 - 10 * i);
        @(negedge clk);
        force u_dut0.next_queue = pre;
        force u_dut0.next_size  = 4'd15;
        @(negedge clk);
        release u_dut0.next_queue;
        release u_dut0.next_size;
        check("preload full", int'(b_full), 1);
        check("preload data", int'(b_q), 150);

        for (int i = 0; i < 7; i++) begin
            op(1'b1, 1'b0, 1'b1, 0, 3);
            check($sformatf("ro deq%0d data", i), int'(b_q), 140 - 10 * i);
            check($sformatf("ro deq%0d size", i), int'(u_dut0.size), 14 - i);
            check($sformatf("ro deq%0d full", i), int'(b_full), 0);
        end
        for (int i = 0; i < 7; i++) begin
            op(1'b1, 1'b1, 1'b0, 999, 5);
            check($sformatf("ro enq%0d data", i), int'(b_q), 80);
            check($sformatf("ro enq%0d size", i), int'(u_dut0.size), 8);
            check($sformatf("ro enq%0d full", i), int'(b_full), 0);
            check($sformatf("ro enq%0d empty", i), int'(b_empty), 0);
        end

        // Replace stream against a multiset model
        for (int i = 0; i < 8; i++) model.push_back(80 - 10 * i);
        for (int i = 0; i < 12; i++) begin
            int v;
            int mi;
            int mx;
            v  = int'($urandom_range(1024, 0));
            mi = 0;
            for (int k = 1; k < model.size(); k++) if (model[k] > model[mi]) mi = k;
            model.delete(mi);
            model.push_back(v);
            mx = 0;
            for (int k = 0; k < model.size(); k++) if (model[k] > mx) mx = model[k];
            op(1'b1, 1'b1, 1'b1, v, 3);
            check($sformatf("ro rep%0d data", i), int'(b_q), mx);
            check($sformatf("ro rep%0d size", i), int'(u_dut0.size), 8);
        end

        // Asynchronous reset between edges
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst a_empty", int'(a_empty), 1);
        check("arst a_data", int'(a_q), 0);
        check("arst b_data", int'(b_q), 0);
        check("arst b_size", int'(u_dut0.size), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
